// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/compare sequencer.
// Holds the controller state encoding and the bit-counter sizing helper.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 3;

    // One extra count value so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_slice_fa.sv
// Single full-adder bit slice, time-shared by the serial controller.
// Purely combinational.
module bit_slice_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_cmp_ctrl.sv
// Bit-serial (LSB first) adder and magnitude comparator built around one
// full-adder slice, with valid/ready handshakes on operand and result sides.
module serial_add_cmp_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_gt
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_idx;
    logic             r_carry;
    logic             r_lt;
    logic             r_gt;
    logic [WIDTH-1:0] r_sum_work;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_lt_o;
    logic             r_eq_o;
    logic             r_gt_o;

    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;
    logic             w_lt_next;
    logic             w_gt_next;
    logic [WIDTH-1:0] w_sum_work_next;

    // Shift-based bit pick keeps the select legal for any counter width.
    assign w_a_shift = r_a >> r_idx;
    assign w_b_shift = r_b >> r_idx;
    assign w_a_bit   = w_a_shift[0];
    assign w_b_bit   = w_b_shift[0];
    assign w_last    = (r_idx == CW'(WIDTH - 1));

    bit_slice_fa u_slice (
        .a    (w_a_bit),
        .b    (w_b_bit),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // A differing bit decides the relation; higher bits arrive later and win.
    assign w_lt_next       = (w_a_bit != w_b_bit) ? ~w_a_bit : r_lt;
    assign w_gt_next       = (w_a_bit != w_b_bit) ?  w_a_bit : r_gt;
    assign w_sum_work_next = r_sum_work | (WIDTH'(w_sum) << r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_lt       <= 1'b0;
            r_gt       <= 1'b0;
            r_sum_work <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_lt_o     <= 1'b0;
            r_eq_o     <= 1'b0;
            r_gt_o     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_idx      <= '0;
                        r_carry    <= 1'b0;
                        r_lt       <= 1'b0;
                        r_gt       <= 1'b0;
                        r_sum_work <= '0;
                    end
                end
                RUN: begin
                    r_sum_work <= w_sum_work_next;
                    r_carry    <= w_cout;
                    r_lt       <= w_lt_next;
                    r_gt       <= w_gt_next;
                    if (w_last) begin
                        r_sum  <= w_sum_work_next;
                        r_cout <= w_cout;
                        r_lt_o <= w_lt_next;
                        r_gt_o <= w_gt_next;
                        r_eq_o <= ~(w_lt_next | w_gt_next);
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_lt    = r_lt_o;
    assign out_eq    = r_eq_o;
    assign out_gt    = r_gt_o;

endmodule
